// File: rtl/mips_debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_debug_pkg
//  Description : Shared encodings for the UART debug controller: FSM states,
//                serializer phases, command bytes and frame word indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_debug_pkg;

    // Top-level controller states; values are visible on the LED port
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_RUN        = 4'd1,
        ST_STEP_WAIT  = 4'd2,
        ST_STEP_PULSE = 4'd3,
        ST_DUMP_LOAD  = 4'd4,
        ST_DUMP_BYTE  = 4'd5,
        ST_DUMP_WAIT  = 4'd6
    } state_e;

    // Byte-level phases inside the serializer
    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_BYTE = 2'd1,
        SER_WAIT = 2'd2
    } ser_phase_e;

    // ASCII command bytes
    localparam logic [7:0] CMD_RUN  = 8'h72;  // 'r'
    localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_NEXT = 8'h6E;  // 'n'
    localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'
    localparam logic [7:0] CMD_EXIT = 8'h78;  // 'x'

    // Word positions inside a dump frame
    localparam int WORD_PC   = 0;
    localparam int WORD_CNT  = 1;
    localparam int WORD_REG0 = 2;

    // Number of words in one frame: PC, count, registers, memory
    function automatic int frame_words(input int n_regs, input int n_mem);
        return WORD_REG0 + n_regs + n_mem;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_debug_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_debug_ctrl_if
//  Description : UART RX/TX handshake bundle between the UART pair and the
//                debug controller. The controller uses the slave modport,
//                the UART side uses the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_debug_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_uart_rx_valid;
    logic [DATA_BITS-1:0] i_uart_rx_data;
    logic                 o_uart_rx_ack;
    logic [DATA_BITS-1:0] o_uart_tx_data;
    logic                 o_uart_tx_start;
    logic                 i_uart_tx_busy;

    modport slave (
        input  i_uart_rx_valid,
        input  i_uart_rx_data,
        input  i_uart_tx_busy,
        output o_uart_rx_ack,
        output o_uart_tx_data,
        output o_uart_tx_start
    );

    modport master (
        output i_uart_rx_valid,
        output i_uart_rx_data,
        output i_uart_tx_busy,
        input  o_uart_rx_ack,
        input  o_uart_tx_data,
        input  o_uart_tx_start
    );
endinterface
`default_nettype wire

// File: rtl/mips_debug_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : mips_debug_serializer
//  Description : Splits an NBITS word into DATA_BITS bytes, MSB first, and
//                runs the start/busy handshake with the UART transmitter.
//                o_word_done is asserted in the cycle the last byte completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_debug_serializer
    import mips_debug_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int NBITS     = 32
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 i_load,
    input  wire logic [NBITS-1:0]     i_word,
    input  wire logic                 i_tx_busy,
    output logic      [DATA_BITS-1:0] o_tx_data,
    output logic                      o_tx_start,
    output logic                      o_waiting,
    output logic                      o_word_done
);
    localparam int NBYTES   = NBITS / DATA_BITS;
    localparam int CNT_BITS = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_BITS-1:0] LAST_BYTE = CNT_BITS'(NBYTES - 1);

    generate
        if (NBITS % DATA_BITS != 0) begin : g_width_check
            $error("NBITS must be a multiple of DATA_BITS");
        end
    endgenerate

    ser_phase_e            phase_q;
    logic [NBITS-1:0]      shreg_q;
    logic [CNT_BITS-1:0]   byte_q;
    logic                  busy_seen_q;
    logic [DATA_BITS-1:0]  tx_data_q;
    logic                  tx_start_q;

    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_waiting   = (phase_q == SER_WAIT);
    assign o_word_done = (phase_q == SER_WAIT) && busy_seen_q && !i_tx_busy
                         && (byte_q == LAST_BYTE);

    // Byte sequencer: load word, send top byte when idle, wait busy rise/fall, shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= SER_IDLE;
            shreg_q     <= '0;
            byte_q      <= '0;
            busy_seen_q <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (phase_q)
                SER_IDLE: begin
                    if (i_load) begin
                        shreg_q <= i_word;
                        byte_q  <= '0;
                        phase_q <= SER_BYTE;
                    end
                end
                SER_BYTE: begin
                    if (!i_tx_busy) begin
                        tx_data_q   <= shreg_q[NBITS-1 -: DATA_BITS];
                        tx_start_q  <= 1'b1;
                        busy_seen_q <= 1'b0;
                        phase_q     <= SER_WAIT;
                    end
                end
                SER_WAIT: begin
                    if (!busy_seen_q) begin
                        if (i_tx_busy) begin
                            busy_seen_q <= 1'b1;
                        end
                    end else if (!i_tx_busy) begin
                        shreg_q <= shreg_q << DATA_BITS;
                        if (byte_q == LAST_BYTE) begin
                            phase_q <= SER_IDLE;
                        end else begin
                            byte_q  <= byte_q + 1'b1;
                            phase_q <= SER_BYTE;
                        end
                    end
                end
                default: phase_q <= SER_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_debug_ctrl
//  Description : UART-driven debug controller for the MIPS core. Runs the
//                core to HALT or single-steps it through a clock enable, then
//                streams PC, cycle count, register file and data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_debug_ctrl
    import mips_debug_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int NBITS     = 32,
    parameter int N_REGS    = 32,
    parameter int N_MEM     = 16,
    parameter int ADDR_BITS = 5
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    mips_debug_ctrl_if.slave          uart,
    input  wire logic                 i_mips_halt,
    input  wire logic [NBITS-1:0]     i_mips_pc,
    output logic                      o_mips_en,
    output logic                      o_mips_reset,
    output logic                      o_dbg_sel,
    output logic      [ADDR_BITS-1:0] o_dbg_addr,
    input  wire logic [NBITS-1:0]     i_dbg_data,
    output logic      [3:0]           o_state
);
    localparam int W        = frame_words(N_REGS, N_MEM);
    localparam int IDX_BITS = $clog2(W);
    localparam logic [IDX_BITS-1:0] LAST_WORD = IDX_BITS'(W - 1);

    localparam logic [DATA_BITS-1:0] RX_RUN  = DATA_BITS'(CMD_RUN);
    localparam logic [DATA_BITS-1:0] RX_STEP = DATA_BITS'(CMD_STEP);
    localparam logic [DATA_BITS-1:0] RX_NEXT = DATA_BITS'(CMD_NEXT);
    localparam logic [DATA_BITS-1:0] RX_DUMP = DATA_BITS'(CMD_DUMP);
    localparam logic [DATA_BITS-1:0] RX_EXIT = DATA_BITS'(CMD_EXIT);

    state_e               state_q;
    state_e               ret_q;
    logic [IDX_BITS-1:0]  idx_q;
    logic                 ld_phase_q;
    logic [NBITS-1:0]     pc_snap_q;
    logic [NBITS-1:0]     cnt_snap_q;
    logic [NBITS-1:0]     cnt_q;
    logic                 dbg_sel_q;
    logic [ADDR_BITS-1:0] dbg_addr_q;

    logic                 w_rx_take;
    logic                 w_mips_en;
    logic                 w_ser_load;
    logic [NBITS-1:0]     w_ser_word;
    logic                 w_ser_wait;
    logic                 w_word_done;
    logic [IDX_BITS-1:0]  w_idx_next;
    logic [DATA_BITS-1:0] w_tx_data;
    logic                 w_tx_start;

    // Register-file words come first, then data memory
    function automatic logic sel_of(input logic [IDX_BITS-1:0] idx);
        return int'(idx) >= (WORD_REG0 + N_REGS);
    endfunction

    function automatic logic [ADDR_BITS-1:0] addr_of(input logic [IDX_BITS-1:0] idx);
        int a;
        a = int'(idx);
        if (a >= WORD_REG0 + N_REGS) begin
            a = a - WORD_REG0 - N_REGS;
        end else if (a >= WORD_REG0) begin
            a = a - WORD_REG0;
        end else begin
            a = 0;
        end
        return ADDR_BITS'(a);
    endfunction

    // Bytes are consumed only where a command can be interpreted; during a
    // step pulse or a dump they stay pending until the next accepting state.
    assign w_rx_take = uart.i_uart_rx_valid &&
                       (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_STEP_WAIT);
    assign uart.o_uart_rx_ack = w_rx_take && !reset;

    // Combinational enable so the core stops in the very cycle HALT is seen
    assign w_mips_en = ((state_q == ST_RUN) && !i_mips_halt) || (state_q == ST_STEP_PULSE);
    assign o_mips_en    = w_mips_en;
    assign o_mips_reset = (state_q == ST_IDLE);

    assign o_dbg_sel  = dbg_sel_q;
    assign o_dbg_addr = dbg_addr_q;
    assign w_idx_next = idx_q + 1'b1;

    // Second LOAD cycle: read data is valid, hand the word to the serializer
    assign w_ser_load = (state_q == ST_DUMP_LOAD) && ld_phase_q;
    assign w_ser_word = (idx_q == IDX_BITS'(WORD_PC))  ? pc_snap_q  :
                        (idx_q == IDX_BITS'(WORD_CNT)) ? cnt_snap_q : i_dbg_data;

    assign o_state = (state_q == ST_DUMP_BYTE && w_ser_wait) ? ST_DUMP_WAIT : state_q;

    mips_debug_serializer #(
        .DATA_BITS (DATA_BITS),
        .NBITS     (NBITS)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_ser_load),
        .i_word      (w_ser_word),
        .i_tx_busy   (uart.i_uart_tx_busy),
        .o_tx_data   (w_tx_data),
        .o_tx_start  (w_tx_start),
        .o_waiting   (w_ser_wait),
        .o_word_done (w_word_done)
    );

    assign uart.o_uart_tx_data  = w_tx_data;
    assign uart.o_uart_tx_start = w_tx_start;

    // Command/run-control FSM with cycle counter and frame word sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            idx_q      <= '0;
            ld_phase_q <= 1'b0;
            pc_snap_q  <= '0;
            cnt_snap_q <= '0;
            cnt_q      <= '0;
            dbg_sel_q  <= 1'b0;
            dbg_addr_q <= '0;
        end else begin
            if (w_mips_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_rx_take) begin
                        if (uart.i_uart_rx_data == RX_RUN) begin
                            state_q <= ST_RUN;
                            cnt_q   <= '0;
                        end else if (uart.i_uart_rx_data == RX_STEP) begin
                            state_q <= ST_STEP_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_mips_halt) begin
                        state_q    <= ST_DUMP_LOAD;
                        ret_q      <= ST_IDLE;
                        idx_q      <= '0;
                        ld_phase_q <= 1'b0;
                    end
                end
                ST_STEP_WAIT: begin
                    if (w_rx_take) begin
                        if (uart.i_uart_rx_data == RX_EXIT) begin
                            state_q <= ST_IDLE;
                        end else if (uart.i_uart_rx_data == RX_NEXT) begin
                            state_q <= ST_STEP_PULSE;
                        end else if (uart.i_uart_rx_data == RX_DUMP) begin
                            state_q    <= ST_DUMP_LOAD;
                            ret_q      <= ST_STEP_WAIT;
                            idx_q      <= '0;
                            ld_phase_q <= 1'b0;
                        end
                    end
                end
                ST_STEP_PULSE: begin
                    state_q    <= ST_DUMP_LOAD;
                    ret_q      <= ST_STEP_WAIT;
                    idx_q      <= '0;
                    ld_phase_q <= 1'b0;
                end
                ST_DUMP_LOAD: begin
                    if (!ld_phase_q) begin
                        ld_phase_q <= 1'b1;
                        // Frame entry: snapshot PC/count and decide where to return
                        if (idx_q == '0) begin
                            pc_snap_q  <= i_mips_pc;
                            cnt_snap_q <= cnt_q;
                            if (i_mips_halt) begin
                                ret_q <= ST_IDLE;
                            end
                        end
                    end else begin
                        ld_phase_q <= 1'b0;
                        state_q    <= ST_DUMP_BYTE;
                    end
                end
                ST_DUMP_BYTE: begin
                    if (w_word_done) begin
                        if (idx_q == LAST_WORD) begin
                            state_q    <= ret_q;
                            idx_q      <= '0;
                            dbg_sel_q  <= 1'b0;
                            dbg_addr_q <= '0;
                        end else begin
                            idx_q      <= w_idx_next;
                            dbg_sel_q  <= sel_of(w_idx_next);
                            dbg_addr_q <= addr_of(w_idx_next);
                            state_q    <= ST_DUMP_LOAD;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_debug_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mips_debug_ctrl
//  Description : Directed bench for mips_debug_ctrl with a tiny core model
//                (3 instructions then HALT at 0x0C), debug-port memory model
//                and a UART TX model with adjustable busy length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_debug_ctrl;
    import mips_debug_pkg::*;

    localparam int DATA_BITS   = 8;
    localparam int NBITS       = 32;
    localparam int N_REGS      = 32;
    localparam int N_MEM       = 16;
    localparam int ADDR_BITS   = 5;
    localparam int FRAME_BYTES = (2 + N_REGS + N_MEM) * (NBITS / DATA_BITS);
    localparam int BUDGET      = 20000;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 mips_halt;
    logic [NBITS-1:0]     mips_pc;
    logic                 mips_en;
    logic                 mips_reset;
    logic                 dbg_sel;
    logic [ADDR_BITS-1:0] dbg_addr;
    logic [NBITS-1:0]     dbg_data;
    logic [3:0]           state;

    int checks = 0;
    int errors = 0;

    mips_debug_ctrl_if #(.DATA_BITS(DATA_BITS)) uart ();

    mips_debug_ctrl #(
        .DATA_BITS (DATA_BITS),
        .NBITS     (NBITS),
        .N_REGS    (N_REGS),
        .N_MEM     (N_MEM),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart         (uart),
        .i_mips_halt  (mips_halt),
        .i_mips_pc    (mips_pc),
        .o_mips_en    (mips_en),
        .o_mips_reset (mips_reset),
        .o_dbg_sel    (dbg_sel),
        .o_dbg_addr   (dbg_addr),
        .i_dbg_data   (dbg_data),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    // Core model: HALT instruction lives at 0x0C
    logic [NBITS-1:0] core_pc;
    logic             core_halt;
    always @(posedge clk) begin
        if (mips_reset) begin
            core_pc   <= '0;
            core_halt <= 1'b0;
        end else if (mips_en) begin
            if (core_pc == 32'h0000_000C) core_halt <= 1'b1;
            else                          core_pc   <= core_pc + 32'd4;
        end
    end
    assign mips_pc   = core_pc;
    assign mips_halt = core_halt;

    // Debug read port: one-cycle latency
    always @(posedge clk) begin
        dbg_data <= dbg_sel ? (32'hA500_0000 | {27'd0, dbg_addr})
                            : (32'h5A00_0000 | {27'd0, dbg_addr});
    end

    // UART TX model
    int         busy_len = 3;
    int         busy_cnt = 0;
    logic [7:0] txq[$];
    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 0;
        end else if (uart.o_uart_tx_start) begin
            checks++;
            assert (uart.i_uart_tx_busy === 1'b0) else begin
                errors++;
                $error("FAIL start_while_busy observed=%0b expected=0", uart.i_uart_tx_busy);
            end
            txq.push_back(uart.o_uart_tx_data);
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign uart.i_uart_tx_busy = (busy_cnt != 0);

    // Monitors
    int               en_cnt = 0;
    int               ack_cnt = 0;
    bit               halt_seen = 0;
    bit               seen_wait = 0;
    bit               got_first = 0;
    logic [NBITS-1:0] first_pc = '1;
    always @(posedge clk) begin
        if (mips_en === 1'b1) begin
            en_cnt++;
            if (!got_first) begin
                first_pc  = core_pc;
                got_first = 1;
            end
        end
        if (uart.o_uart_rx_ack === 1'b1) ack_cnt++;
        if (mips_halt === 1'b1) halt_seen = 1;
        if (state == 4'd6) seen_wait = 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [31:0] pc, input logic [31:0] cnt);
        int          w;
        int          k;
        logic [31:0] word;
        w = i / 4;
        k = i % 4;
        if (w == 0)               word = pc;
        else if (w == 1)          word = cnt;
        else if (w < 2 + N_REGS)  word = 32'h5A00_0000 | 32'(w - 2);
        else                      word = 32'hA500_0000 | 32'(w - 2 - N_REGS);
        return word[31 - 8*k -: 8];
    endfunction

    task automatic check_frame(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
        int nbad;
        nbad = 0;
        check({tag, "_len"}, 64'(txq.size()), 64'(FRAME_BYTES));
        for (int i = 0; i < txq.size() && i < FRAME_BYTES; i++) begin
            if (txq[i] !== exp_byte(i, pc, cnt)) nbad++;
        end
        check({tag, "_bad_bytes"}, 64'(nbad), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 0;
        @(posedge clk); #1;
        uart.i_uart_rx_valid = 1'b1;
        uart.i_uart_rx_data  = b;
        for (int i = 0; i < BUDGET && !done; i++) begin
            @(negedge clk);
            if (uart.o_uart_rx_ack === 1'b1) done = 1;
        end
        @(posedge clk); #1;
        uart.i_uart_rx_valid = 1'b0;
        check("rx_ack_seen", 64'(done), 64'd1);
    endtask

    task automatic wait_state(input logic [3:0] s);
        bit found;
        found = 0;
        for (int i = 0; i < BUDGET && !found; i++) begin
            @(negedge clk);
            if (state == s) found = 1;
        end
        check("state_reached", 64'(found), 64'd1);
    endtask

    initial begin
        uart.i_uart_rx_valid = 1'b0;
        uart.i_uart_rx_data  = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state",      64'(state), 64'd0);
        check("rst_mips_reset", 64'(mips_reset), 64'd1);
        check("rst_mips_en",    64'(mips_en), 64'd0);
        check("rst_rx_ack",     64'(uart.o_uart_rx_ack), 64'd0);
        check("rst_tx_start",   64'(uart.o_uart_tx_start), 64'd0);
        check("rst_tx_data",    64'(uart.o_uart_tx_data), 64'd0);
        check("rst_dbg_sel",    64'(dbg_sel), 64'd0);
        check("rst_dbg_addr",   64'(dbg_addr), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Run to HALT
        txq.delete(); en_cnt = 0; halt_seen = 0; seen_wait = 0;
        send_byte(CMD_RUN);
        wait_state(4'd4);
        wait_state(4'd0);
        check("run_en_cycles",  64'(en_cnt), 64'd4);
        check("run_halt_seen",  64'(halt_seen), 64'd1);
        check("run_mips_reset", 64'(mips_reset), 64'd1);
        check("run_saw_wait",   64'(seen_wait), 64'd1);
        check_frame("run_frame", 32'h0000_000C, 32'd4);

        // Step mode, two steps
        send_byte(CMD_STEP);
        @(negedge clk);
        check("step_state", 64'(state), 64'd2);
        txq.delete(); en_cnt = 0;
        send_byte(CMD_NEXT);
        wait_state(4'd4);
        wait_state(4'd2);
        check("step1_en", 64'(en_cnt), 64'd1);
        check_frame("step1_frame", 32'h0000_0004, 32'd1);
        txq.delete(); en_cnt = 0;
        send_byte(CMD_NEXT);
        wait_state(4'd4);
        wait_state(4'd2);
        check("step2_en", 64'(en_cnt), 64'd1);
        check_frame("step2_frame", 32'h0000_0008, 32'd2);

        // Dump without stepping, then exit
        txq.delete(); en_cnt = 0;
        send_byte(CMD_DUMP);
        wait_state(4'd4);
        wait_state(4'd2);
        check("dump_en", 64'(en_cnt), 64'd0);
        check_frame("dump_frame", 32'h0000_0008, 32'd2);
        send_byte(CMD_EXIT);
        @(negedge clk);
        check("exit_state",      64'(state), 64'd0);
        check("exit_mips_reset", 64'(mips_reset), 64'd1);

        // Unknown byte in IDLE and STEP_WAIT
        txq.delete(); ack_cnt = 0;
        send_byte(8'h41);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("unk_idle_state", 64'(state), 64'd0);
        check("unk_idle_acks",  64'(ack_cnt), 64'd1);
        check("unk_idle_tx",    64'(txq.size()), 64'd0);
        send_byte(CMD_STEP);
        ack_cnt = 0;
        send_byte(8'h41);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("unk_step_state", 64'(state), 64'd2);
        check("unk_step_acks",  64'(ack_cnt), 64'd1);
        check("unk_step_tx",    64'(txq.size()), 64'd0);
        send_byte(CMD_EXIT);
        @(negedge clk);
        check("unk_exit_state", 64'(state), 64'd0);

        // Backpressure: long busy per byte
        busy_len = 20;
        txq.delete();
        send_byte(CMD_RUN);
        wait_state(4'd4);
        wait_state(4'd0);
        check_frame("bp_frame", 32'h0000_000C, 32'd4);
        busy_len = 3;

        // Reset during byte 5 of a frame
        txq.delete();
        send_byte(CMD_RUN);
        begin
            bit reached;
            reached = 0;
            for (int i = 0; i < BUDGET && !reached; i++) begin
                @(negedge clk);
                if (txq.size() >= 5) reached = 1;
            end
            check("abort_byte5_reached", 64'(reached), 64'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_state",      64'(state), 64'd0);
        check("abort_mips_reset", 64'(mips_reset), 64'd1);
        check("abort_mips_en",    64'(mips_en), 64'd0);
        check("abort_tx_start",   64'(uart.o_uart_tx_start), 64'd0);
        check("abort_tx_data",    64'(uart.o_uart_tx_data), 64'd0);
        check("abort_dbg_sel",    64'(dbg_sel), 64'd0);
        check("abort_dbg_addr",   64'(dbg_addr), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        txq.delete(); en_cnt = 0; got_first = 0;
        send_byte(CMD_RUN);
        wait_state(4'd4);
        wait_state(4'd0);
        check("rerun_first_pc", 64'(first_pc), 64'd0);
        check("rerun_en",       64'(en_cnt), 64'd4);
        check_frame("rerun_frame", 32'h0000_000C, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
- UART-driven debug controller for the MIPS core, sitting between the UART RX/TX pair and the processor top.
- Runs the core to halt or single-steps it, then streams a state frame over UART: PC, cycle count, N_REGS register-file words and N_MEM data-memory words.
- The core is advanced through a clock enable instead of a gated clock.
- Dump contents, word width and byte width are parametrised.

Parameters:
- DATA_BITS, 8, UART byte width.
- NBITS, 32, MIPS word width; must be a multiple of DATA_BITS.
- N_REGS, 32, register-file words dumped, indices 0..N_REGS-1.
- N_MEM, 16, data-memory words dumped, word addresses 0..N_MEM-1.
- ADDR_BITS, 5, debug read-port address width; 2**ADDR_BITS >= max(N_REGS, N_MEM).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- i_uart_rx_valid  in  1  received byte available; held until acked.
- i_uart_rx_data  in  DATA_BITS  received byte.
- o_uart_rx_ack  out  1  one-cycle pulse; consumes the RX byte.
- o_uart_tx_data  out  DATA_BITS  byte to send; stable while busy.
- o_uart_tx_start  out  1  one-cycle pulse; starts transmission.
- i_uart_tx_busy  in  1  TX busy; rises the cycle after start.
- i_mips_halt  in  1  core executed HALT.
- i_mips_pc  in  NBITS  current PC.
- o_mips_en  out  1  core clock enable.
- o_mips_reset  out  1  core synchronous reset.
- o_dbg_sel  out  1  0 = register file, 1 = data memory.
- o_dbg_addr  out  ADDR_BITS  debug read address.
- i_dbg_data  in  NBITS  read data, valid one cycle after address.
- o_state  out  4  current FSM state, for LEDs.

Behaviour:
- Reset values:
  - state IDLE; o_mips_reset=1; o_mips_en=0.
  - o_uart_rx_ack=0, o_uart_tx_start=0, o_uart_tx_data=0.
  - o_dbg_sel=0, o_dbg_addr=0; cycle counter 0.
- Reset mid-frame aborts immediately. No partial byte is re-sent.
- Commands:
  - 'r'=0x72 run; 's'=0x73 step mode; 'n'=0x6E next; 'd'=0x64 dump; 'x'=0x78 exit.
  - Every valid RX byte is acked with exactly one o_uart_rx_ack pulse in the cycle it is sampled.
  - Bytes not legal in the current state are acked and ignored.
- IDLE:
  - o_mips_reset=1. Only 'r' and 's' are accepted.
  - 'r' -> RUN. 's' -> STEP_WAIT. Cycle counter clears on either.
- RUN:
  - o_mips_reset=0. o_mips_en = (state==RUN) & ~i_mips_halt, combinational, so no instruction executes after the halt cycle.
  - On i_mips_halt -> DUMP, with return target IDLE.
- STEP_WAIT:
  - o_mips_reset=0, o_mips_en=0.
  - 'n' -> STEP_PULSE. 'd' -> DUMP, return STEP_WAIT. 'x' -> IDLE.
- STEP_PULSE:
  - o_mips_en=1 for exactly one clk, then -> DUMP.
  - Return target is IDLE if i_mips_halt is high the cycle after the pulse, else STEP_WAIT.
  - 'n' arriving while the frame is being sent stays unacked until STEP_WAIT.
- Cycle counter:
  - NBITS wide; increments on every cycle with o_mips_en=1.
  - Wraps 2**NBITS-1 -> 0.
- Dump frame:
  - Word order: PC, cycle count, REG[0..N_REGS-1], MEM[0..N_MEM-1]. Total W = 2+N_REGS+N_MEM words.
  - Each word is sent as NBITS/DATA_BITS bytes, MSB first.
  - PC and count are latched on DUMP entry, so the frame is a consistent snapshot.
- DUMP sub-states:
  - LOAD: drive o_dbg_sel/o_dbg_addr for reg/mem words. Capture i_dbg_data (or PC/count) into a shift register one cycle later.
  - BYTE: when ~i_uart_tx_busy, drive the top byte and pulse start.
  - WAIT: wait for busy to rise, then fall. Shift left DATA_BITS. Move to the next byte, or back to LOAD for the next word.
  - After the last byte of word W-1, go to the return target. If the target is IDLE, o_mips_reset reasserts the same cycle.
- Simultaneous events:
  - i_mips_halt in the same cycle as RX 'x' in STEP_WAIT: 'x' wins, since the core is not enabled.
  - If i_uart_tx_busy is stuck high, the FSM waits indefinitely. No timeout.
- o_state encodings: IDLE=0, RUN=1, STEP_WAIT=2, STEP_PULSE=3, DUMP_LOAD=4, DUMP_BYTE=5, DUMP_WAIT=6.

Decomposition:
- Package mips_debug_pkg:
  - State encodings.
  - Command byte constants (CMD_RUN, CMD_STEP, CMD_NEXT, CMD_DUMP, CMD_EXIT).
  - Frame word-index constants.
- Sub-module mips_debug_serializer:
  - Word-to-byte shifter plus TX handshake.
  - Inputs: load pulse and NBITS word. Outputs: word_done.
  - Keeps the top FSM to command and run control.

Test Plan:
- Program of 3 instructions then HALT at PC 0x0C; send 'r' -> exactly 4 enable cycles, halt seen.
  - TX bytes 00 00 00 0C, 00 00 00 04, then 4*(N_REGS+N_MEM) bytes.
  - o_mips_reset=1 after the last byte; state IDLE.
- 's', then 'n' twice -> exactly one o_mips_en cycle per 'n'.
  - Frames show PC 0x04 then 0x08, count 1 then 2.
  - State returns to 2 after each frame.
- In STEP_WAIT, 'd' -> frame sent with unchanged PC/count, no enable pulse. Then 'x' -> IDLE, reset high.
- Unknown byte 0x41 in IDLE and in STEP_WAIT -> one ack pulse each, no state change, no TX.
- Backpressure: i_uart_tx_busy held 20 cycles per byte -> o_uart_tx_start never pulses while busy, and byte order is unchanged.
- Assert reset during byte 5 of a frame -> all outputs at reset values next cycle. A new 'r' runs from PC 0 with count 0.
